// File: rtl/i2c_target.sv
// I2C/SCCB target: oversamples SCL/SDA, decodes START/STOP, address, register pointer and
// write data, and serves reads from an external register bank with pointer auto-increment.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_FSM,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t                 state_r;
    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_d_r;
    logic                   sda_d_r;
    logic [7:0]             shift_r;
    logic [3:0]             bit_cnt_r;
    logic                   rw_r;
    logic                   ack_on_r;
    logic                   sda_oe_r;

    logic       scl_s;
    logic       sda_s;
    logic       scl_rise_s;
    logic       scl_fall_s;
    logic       start_s;
    logic       stop_s;
    logic [7:0] byte_s;

    assign scl_s      = scl_sync_r[SYNC_STAGES-1];
    assign sda_s      = sda_sync_r[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_d_r;
    assign scl_fall_s = ~scl_s & scl_d_r;
    assign start_s    = scl_s & scl_d_r & sda_d_r & ~sda_s;
    assign stop_s     = scl_s & scl_d_r & ~sda_d_r & sda_s;
    assign byte_s     = {shift_r[6:0], sda_s};

    // Open drain: the line is only ever pulled low or released.
    assign SDA = sda_oe_r ? 1'b0 : 1'bz;

    // Input synchronisers plus edge-detect flops; reset to the idle-bus level.
    always_ff @(posedge clk_FSM or negedge rst) begin
        if (!rst) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], SCL};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], SDA};
            scl_d_r    <= scl_s;
            sda_d_r    <= sda_s;
        end
    end

    // Bus protocol FSM; START/STOP outrank bit handling in the same cycle.
    always_ff @(posedge clk_FSM or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            shift_r   <= 8'h00;
            bit_cnt_r <= 4'd0;
            rw_r      <= 1'b0;
            ack_on_r  <= 1'b0;
            sda_oe_r  <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            if (start_s) begin
                state_r   <= ADDR;
                bit_cnt_r <= 4'd0;
                ack_on_r  <= 1'b0;
                sda_oe_r  <= 1'b0;
            end else if (stop_s) begin
                state_r   <= IDLE;
                bit_cnt_r <= 4'd0;
                ack_on_r  <= 1'b0;
                sda_oe_r  <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state_r)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise_s) begin
                            shift_r   <= byte_s;
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (bit_cnt_r == 4'd7) begin
                                bit_cnt_r <= 4'd0;
                                case (state_r)
                                    ADDR: begin
                                        if (byte_s[7:1] == DEV_ADDR) begin
                                            state_r <= ADDR_ACK;
                                            rw_r    <= byte_s[0];
                                            busy    <= 1'b1;
                                        end else begin
                                            state_r <= IGNORE;
                                            busy    <= 1'b0;
                                        end
                                    end
                                    PTR: begin
                                        reg_addr <= byte_s;
                                        state_r  <= PTR_ACK;
                                    end
                                    WDATA: begin
                                        reg_wdata <= byte_s;
                                        reg_we    <= 1'b1;
                                        state_r   <= WDATA_ACK;
                                    end
                                    default: state_r <= IDLE;
                                endcase
                            end
                        end
                    end
                    // First falling event pulls the ACK low, the second releases it.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_on_r) begin
                                sda_oe_r <= 1'b1;
                                ack_on_r <= 1'b1;
                            end else begin
                                ack_on_r  <= 1'b0;
                                sda_oe_r  <= 1'b0;
                                bit_cnt_r <= 4'd0;
                                case (state_r)
                                    ADDR_ACK: begin
                                        if (rw_r) begin
                                            shift_r  <= reg_rdata;
                                            sda_oe_r <= ~reg_rdata[7];
                                            state_r  <= RDATA;
                                        end else begin
                                            state_r <= PTR;
                                        end
                                    end
                                    PTR_ACK: state_r <= WDATA;
                                    WDATA_ACK: begin
                                        reg_addr <= reg_addr + 8'd1;
                                        state_r  <= WDATA;
                                    end
                                    default: state_r <= IDLE;
                                endcase
                            end
                        end
                    end
                    // MSB is already on the line; each rise moves the next bit to shift_r[7].
                    RDATA: begin
                        if (scl_rise_s) begin
                            shift_r   <= byte_s;
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (scl_fall_s) begin
                            if (bit_cnt_r == 4'd8) begin
                                sda_oe_r  <= 1'b0;
                                bit_cnt_r <= 4'd0;
                                state_r   <= RDATA_ACK;
                            end else begin
                                sda_oe_r <= ~shift_r[7];
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise_s) begin
                            reg_addr <= reg_addr + 8'd1;
                            if (sda_s) begin
                                state_r <= IGNORE;
                                busy    <= 1'b0;
                            end else begin
                                ack_on_r <= 1'b1;
                            end
                        end else if (scl_fall_s && ack_on_r) begin
                            ack_on_r <= 1'b0;
                            shift_r  <= reg_rdata;
                            sda_oe_r <= ~reg_rdata[7];
                            state_r  <= RDATA;
                        end
                    end
                    IDLE:    sda_oe_r <= 1'b0;
                    IGNORE:  sda_oe_r <= 1'b0;
                    default: state_r  <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: an I2C initiator model drives directed and random transactions;
// expected bank writes are queued and checked by a monitor watching reg_we.
module tb_i2c_target;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       scl    = 1'b1;
    logic       tb_oe  = 1'b0;
    wire        sda;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       reg_we;
    logic       busy;

    pullup (sda);
    assign sda       = tb_oe ? 1'b0 : 1'bz;
    assign reg_rdata = reg_addr ^ 8'h5A;

    i2c_target #(.DEV_ADDR(7'h21), .SYNC_STAGES(2)) dut (
        .clk_FSM  (clk),
        .rst      (rst),
        .SCL      (scl),
        .SDA      (sda),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_rdata(reg_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int          n_chk       = 0;
    int          n_fail      = 0;
    logic [15:0] wq[$];
    logic [7:0]  tx_q[$];
    logic        watch_busy  = 1'b0;
    logic        watch_drive = 1'b0;
    int          busy_viol   = 0;
    int          drive_viol  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    initial forever begin
        @(negedge clk);
        if (rst && reg_we === 1'b1) begin
            if (wq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         reg_addr, reg_wdata);
            end else begin
                chk("bank_write", {reg_addr, reg_wdata}, wq.pop_front());
            end
        end
        if (watch_busy && busy !== 1'b0) busy_viol++;
        if (watch_drive && !tb_oe && sda === 1'b0) drive_viol++;
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        tb_oe = 1'b0; wclk(5);
        scl   = 1'b1; wclk(10);
        tb_oe = 1'b1; wclk(10);
        scl   = 1'b0; wclk(5);
    endtask

    task automatic i2c_stop();
        tb_oe = 1'b1; wclk(5);
        scl   = 1'b1; wclk(10);
        tb_oe = 1'b0; wclk(10);
    endtask

    task automatic bit_x(input logic b, output logic r);
        tb_oe = ~b; wclk(5);
        scl   = 1'b1; wclk(5);
        r     = sda; wclk(5);
        scl   = 1'b0; wclk(5);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(d[i], r);
        bit_x(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            d[i] = r;
        end
        bit_x(nack, r);
    endtask

    // Write transaction; data bytes come from tx_q. Model: pointer advances once per byte.
    task automatic write_txn(input logic [7:0] devb, input logic [7:0] ptr);
        logic       a;
        logic       match;
        logic [7:0] p;
        logic [7:0] old_addr;
        match    = (devb[7:1] == 7'h21) && !devb[0];
        old_addr = reg_addr;
        p        = ptr;
        if (!match) begin
            busy_viol   = 0;
            drive_viol  = 0;
            watch_busy  = 1'b1;
            watch_drive = 1'b1;
        end
        i2c_start();
        send_byte(devb, a);
        chk("addr_ack", a, match);
        if (match) chk("busy_addressed", busy, 1'b1);
        send_byte(ptr, a);
        chk("ptr_ack", a, match);
        foreach (tx_q[i]) begin
            if (match) wq.push_back({p, tx_q[i]});
            if (match) p = p + 8'd1;
            send_byte(tx_q[i], a);
            chk("data_ack", a, match);
        end
        i2c_stop();
        wclk(4);
        chk("busy_after_stop", busy, 1'b0);
        if (match) begin
            chk("ptr_after_write", reg_addr, p);
        end else begin
            watch_busy  = 1'b0;
            watch_drive = 1'b0;
            chk("mismatch_ptr_kept", reg_addr, old_addr);
            chk("mismatch_busy_low", busy_viol, 0);
            chk("mismatch_sda_undriven", drive_viol, 0);
        end
        tx_q.delete();
    endtask

    // Set pointer, repeated START, read n bytes (ACK all but the last). Bank returns addr^0x5A.
    task automatic read_txn(input logic [7:0] ptr, input int n);
        logic       a;
        logic [7:0] d;
        logic [7:0] p;
        p = ptr;
        i2c_start();
        send_byte(8'h42, a); chk("rd_addr_w_ack", a, 1'b1);
        send_byte(ptr, a);   chk("rd_ptr_ack", a, 1'b1);
        i2c_start();
        send_byte(8'h43, a); chk("rd_addr_r_ack", a, 1'b1);
        chk("rd_busy", busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, d);
            chk("read_byte", d, p ^ 8'h5A);
            p = p + 8'd1;
        end
        chk("sda_released_after_nack", sda, 1'b1);
        chk("busy_after_nack", busy, 1'b0);
        i2c_stop();
        wclk(4);
    endtask

    initial begin
        logic       a;
        logic       r;
        logic [7:0] saved;
        logic [6:0] dev7;
        int         nb;

        // Reset state
        wclk(5);
        chk("reset_sda", sda, 1'b1);
        chk("reset_reg_addr", reg_addr, 8'h00);
        chk("reset_reg_wdata", reg_wdata, 8'h00);
        chk("reset_reg_we", reg_we, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b1;
        wclk(5);

        // 1: simple write
        tx_q.push_back(8'h80);
        write_txn(8'h42, 8'h12);
        // 2: address mismatch
        write_txn(8'h44, 8'h12);
        // 3: burst with pointer wrap
        tx_q.push_back(8'hA1); tx_q.push_back(8'hA2); tx_q.push_back(8'hA3);
        write_txn(8'h42, 8'hFE);
        // 4: read with ACK then NACK
        read_txn(8'h0A, 2);

        // 5: reset during bit 4 of a data byte
        i2c_start();
        send_byte(8'h42, a);
        send_byte(8'h33, a);
        for (int i = 0; i < 3; i++) bit_x(1'b1, r);
        tb_oe = 1'b0; wclk(5);
        scl   = 1'b1; wclk(3);
        rst   = 1'b0; wclk(2);
        chk("abort_sda", sda, 1'b1);
        chk("abort_reg_addr", reg_addr, 8'h00);
        chk("abort_reg_wdata", reg_wdata, 8'h00);
        chk("abort_reg_we", reg_we, 1'b0);
        chk("abort_busy", busy, 1'b0);
        scl = 1'b0; wclk(5);
        scl = 1'b1; wclk(5);
        rst = 1'b1; wclk(10);
        tx_q.push_back(8'h80);
        write_txn(8'h42, 8'h12);

        // 6: STOP after 5 pointer bits leaves the pointer alone
        saved = reg_addr;
        i2c_start();
        send_byte(8'h42, a);
        chk("partial_addr_ack", a, 1'b1);
        drive_viol  = 0;
        watch_drive = 1'b1;
        for (int i = 0; i < 5; i++) bit_x(1'b1, r);
        i2c_stop();
        wclk(30);
        watch_drive = 1'b0;
        chk("partial_ptr_kept", reg_addr, saved);
        chk("partial_busy", busy, 1'b0);
        chk("partial_no_ack", drive_viol, 0);

        // Random transactions
        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 2))
                0: begin
                    nb = $urandom_range(1, 3);
                    for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom_range(0, 255)));
                    write_txn(8'h42, 8'($urandom_range(0, 255)));
                end
                1: read_txn(8'($urandom_range(0, 255)), $urandom_range(1, 3));
                default: begin
                    dev7 = 7'($urandom_range(0, 127));
                    if (dev7 == 7'h21) dev7 = 7'h22;
                    tx_q.push_back(8'($urandom_range(0, 255)));
                    tx_q.push_back(8'($urandom_range(0, 255)));
                    write_txn({dev7, 1'b0}, 8'($urandom_range(0, 255)));
                end
            endcase
        end

        wclk(10);
        chk("pending_writes", wq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
